// File: rtl/simplez_core_if.sv
// Memory/peripheral bus of the SIMPLEZ core: req (rd/wr) held until ack, one word per transfer.
// The core is the master; a memory or slow peripheral stalls it by withholding ack.
interface simplez_core_if #(
  parameter int DATAW = 12,
  parameter int ADDRW = 9
);
  logic [ADDRW-1:0] mem_addr;
  logic             mem_rd;
  logic             mem_wr;
  logic [DATAW-1:0] mem_wdata;
  logic [DATAW-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/simplez.sv
// SIMPLEZ CPU core: fetch I0, decode/execute I1, operand O0, terminate O1, halt H.
// 2 cycles for BR/BZ/CLR/DEC, 4 for LD/ADD/ST with ack high; each cycle without ack stalls in I0/O0.
module simplez_core #(
  parameter int               DATAW    = 12,
  parameter int               ADDRW    = 9,
  parameter logic [ADDRW-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  simplez_core_if.master   bus,
  output logic [DATAW-1:0] ac_out,
  output logic [ADDRW-1:0] pc_out,
  output logic             halted
);

  typedef enum logic [2:0] {
    S_I0,
    S_I1,
    S_O0,
    S_O1,
    S_H
  } state_t;

  localparam logic [2:0] OP_ST   = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [ADDRW-1:0] PC_ONE = {{(ADDRW-1){1'b0}}, 1'b1};
  localparam logic [DATAW-1:0] AC_ONE = {{(DATAW-1){1'b0}}, 1'b1};

  state_t           state, state_n;
  logic [ADDRW-1:0] pc, pc_n;
  logic [DATAW-1:0] ac, ac_n;
  logic [DATAW-1:0] ri, ri_n;
  logic [2:0]       opcode;
  logic [ADDRW-1:0] cd;

  assign opcode = ri[DATAW-1 -: 3];
  assign cd     = ri[ADDRW-1:0];
  assign ac_out = ac;
  assign pc_out = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_I0;
      pc    <= RESET_PC;
      ac    <= '0;
      ri    <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ac    <= ac_n;
      ri    <= ri_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    ac_n          = ac;
    ri_n          = ri;
    bus.mem_addr  = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = '0;
    halted        = 1'b0;

    case (state)
      S_I0: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = pc;
        if (bus.mem_ack) begin
          ri_n    = bus.mem_rdata;
          pc_n    = pc + PC_ONE;
          state_n = S_I1;
        end
      end
      S_I1: begin
        state_n = S_I0;
        case (opcode)
          OP_BR:   pc_n = cd;
          OP_BZ:   if (ac == '0) pc_n = cd;
          OP_CLR:  ac_n = '0;
          OP_DEC:  ac_n = ac - AC_ONE;
          OP_HALT: state_n = S_H;
          default: state_n = S_O0;
        endcase
      end
      S_O0: begin
        bus.mem_addr = cd;
        if (opcode == OP_ST) begin
          bus.mem_wr    = 1'b1;
          bus.mem_wdata = ac;
        end else begin
          bus.mem_rd = 1'b1;
        end
        if (bus.mem_ack) begin
          if (opcode == OP_LD)  ac_n = bus.mem_rdata;
          if (opcode == OP_ADD) ac_n = ac + bus.mem_rdata;
          state_n = S_O1;
        end
      end
      S_O1: state_n = S_I0;
      S_H:  halted  = 1'b1;
      default: state_n = S_I0;
    endcase

    // Reset masks the bus at once so an in-flight write is withdrawn in the reset cycle.
    if (rst) begin
      bus.mem_addr  = '0;
      bus.mem_rd    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_wdata = '0;
      halted        = 1'b0;
    end
  end

endmodule

// File: tb/tb_simplez_core.sv
// Bench for simplez_core: instruction-level SIMPLEZ model checked against bus traffic every cycle.
module tb_simplez_core;
  localparam int DW = 12;
  localparam int AW = 9;

  logic clk;
  logic rst, rst2;
  logic [DW-1:0] ac_out, ac2;
  logic [AW-1:0] pc_out, pc2;
  logic halted, halted2;

  simplez_core_if #(.DATAW(DW), .ADDRW(AW)) bus ();
  simplez_core_if #(.DATAW(DW), .ADDRW(AW)) bus2 ();

  simplez_core #(.DATAW(DW), .ADDRW(AW), .RESET_PC(9'd0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ac_out(ac_out), .pc_out(pc_out), .halted(halted)
  );

  // Second core starting at the top of the address space; every word it reads is CLR.
  simplez_core #(.DATAW(DW), .ADDRW(AW), .RESET_PC(9'd511)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2), .ac_out(ac2), .pc_out(pc2), .halted(halted2)
  );
  assign bus2.mem_ack   = 1'b1;
  assign bus2.mem_rdata = 12'hA00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mem   [0:511];
  logic [DW-1:0] m_mem [0:511];
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_ac;
  bit            m_halt;
  int            hc;
  int            dly_mode;
  bit            force_ack;
  bit            chk_en;
  int            last_dly;
  bit            phase_op;
  logic [2:0]    cur_op;
  logic [AW-1:0] cur_cd;
  bit            prev_req;
  logic [22:0]   prev_bus;
  int            cyc, exp_len, gcyc, halted_at;
  bit            started;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ins(input int op, input int cd);
    return DW'((op << 9) | cd);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) begin
      mem[i]   = '0;
      m_mem[i] = '0;
    end
  endtask

  task automatic put(input int a, input logic [DW-1:0] v);
    mem[a]   = v;
    m_mem[a] = v;
  endtask

  task automatic load_prog1();
    clear_mem();
    put(0, ins(1, 10));
    put(1, ins(2, 11));
    put(2, ins(0, 12));
    put(3, ins(7, 0));
    put(10, 12'd5);
    put(11, 12'd7);
  endtask

  // Memory responder: ack after a chosen number of wait cycles, stray acks when idle.
  initial begin
    int wait_cnt;
    int cur_dly;
    wait_cnt = 0;
    cur_dly = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #3;
      if (!(bus.mem_rd || bus.mem_wr)) begin
        wait_cnt = 0;
        bus.mem_ack = force_ack || (dly_mode < 0 && $urandom_range(0, 3) == 0);
        bus.mem_rdata = DW'($urandom);
      end else begin
        if (wait_cnt == 0) begin
          cur_dly = (dly_mode < 0) ? int'($urandom_range(0, 3)) : dly_mode;
          last_dly = cur_dly;
        end
        bus.mem_ack = force_ack || (wait_cnt >= cur_dly);
        wait_cnt++;
        bus.mem_rdata = bus.mem_rd ? mem[bus.mem_addr] : DW'($urandom);
      end
    end
  end

  task automatic compare_step();
    logic req;
    logic [DW-1:0] instr;
    logic [22:0] cur_bus;
    req = bus.mem_rd | bus.mem_wr;
    cur_bus = {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata};
    gcyc++;
    cyc++;
    if (halted === 1'b1 && halted_at == 0) halted_at = gcyc;
    if (m_halt) hc++;
    chk("halted", 32'(halted), 32'(m_halt && hc >= 2));
    if (m_halt && hc >= 2) begin
      chk("halt_frozen", 32'({req, m_pc, m_ac} ^ {1'b0, pc_out, ac_out}), 32'd0);
    end else if (req && !prev_req) begin
      if (!phase_op) begin
        if (started) chk("instr_len", 32'(cyc - 1), 32'(exp_len));
        started = 1'b1;
        cyc = 1;
        exp_len = last_dly + 1;
        chk("fetch_pc_ac", 32'({pc_out, ac_out}), 32'({m_pc, m_ac}));
        chk("fetch_bus", 32'({bus.mem_rd, bus.mem_wr, bus.mem_addr}), 32'({1'b1, 1'b0, m_pc}));
      end else begin
        exp_len += last_dly + 1;
        if (cur_op == 3'd0)
          chk("st_bus", 32'(cur_bus), 32'({1'b0, 1'b1, cur_cd, m_ac}));
        else
          chk("rd_bus", 32'(cur_bus), 32'({1'b1, 1'b0, cur_cd, 12'd0}));
      end
    end else if (req && prev_req) begin
      chk("req_stable", 32'(cur_bus), 32'(prev_bus));
    end

    if (req && bus.mem_ack && !m_halt) begin
      if (!phase_op) begin
        instr = m_mem[m_pc];
        m_pc = AW'(m_pc + 1);
        cur_op = instr[11:9];
        cur_cd = instr[8:0];
        exp_len += 1;
        case (cur_op)
          3'd3: m_pc = cur_cd;
          3'd4: if (m_ac == '0) m_pc = cur_cd;
          3'd5: m_ac = '0;
          3'd6: m_ac = DW'(m_ac - 1);
          3'd7: begin m_halt = 1'b1; hc = 0; end
          default: begin phase_op = 1'b1; exp_len += 1; end
        endcase
      end else begin
        case (cur_op)
          3'd0: begin
            m_mem[cur_cd] = m_ac;
            mem[bus.mem_addr] = bus.mem_wdata;
          end
          3'd1: m_ac = m_mem[cur_cd];
          default: m_ac = DW'(m_ac + m_mem[cur_cd]);
        endcase
        phase_op = 1'b0;
      end
    end
    prev_req = req;
    prev_bus = cur_bus;
  endtask

  initial begin
    chk_en = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) compare_step();
    end
  end

  // Starts on a posedge+1 boundary one clock later; holds rst for exactly one edge.
  task automatic do_reset(input bit expect_wr);
    chk_en = 1'b0;
    @(posedge clk);
    #1;
    if (expect_wr) chk("st_pending", 32'(bus.mem_wr), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_bus_idle", 32'({bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata, halted}), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_regs", 32'({pc_out, ac_out, halted}), 32'd0);
    m_pc = '0;
    m_ac = '0;
    m_halt = 1'b0;
    hc = 0;
    phase_op = 1'b0;
    prev_req = 1'b0;
    prev_bus = '0;
    started = 1'b0;
    cyc = 0;
    exp_len = 0;
    gcyc = 0;
    halted_at = 0;
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_first_fetch", 32'({bus.mem_rd, bus.mem_wr, bus.mem_addr}), 32'({1'b1, 1'b0, 9'd0}));
  endtask

  task automatic run_until_halt(input int max_cyc);
    for (int i = 0; i < max_cyc && halted !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    chk("halt_reached", 32'(halted), 32'd1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rst2 = 1'b1;
    dly_mode = 0;
    force_ack = 1'b0;
    last_dly = 0;
    clear_mem();

    // PC wrap on a core that resets to 511.
    repeat (2) @(posedge clk);
    #1;
    chk("w_reset_pc", 32'({pc2, ac2, halted2}), 32'({9'd511, 12'd0, 1'b0}));
    rst2 = 1'b0;
    #1;
    chk("w_fetch511", 32'({bus2.mem_rd, bus2.mem_addr}), 32'({1'b1, 9'd511}));
    @(posedge clk);
    #1;
    chk("w_pc_wrapped", 32'({bus2.mem_rd, pc2}), 32'({1'b0, 9'd0}));
    @(posedge clk);
    #1;
    chk("w_fetch0", 32'({bus2.mem_rd, bus2.mem_addr}), 32'({1'b1, 9'd0}));

    // LD/ADD/ST/HALT with ack tied high.
    load_prog1();
    dly_mode = 0;
    do_reset(1'b0);
    run_until_halt(100);
    chk("p1_ac", 32'(ac_out), 32'd12);
    chk("p1_pc", 32'(pc_out), 32'd4);
    chk("p1_mem12", 32'(mem[12]), 32'd12);
    chk("p1_cycles", 32'(halted_at), 32'd15);

    // ADD overflow and DEC underflow, random ack delays.
    clear_mem();
    put(0, ins(1, 10)); put(1, ins(2, 11)); put(2, ins(0, 12)); put(3, ins(5, 0));
    put(4, ins(6, 0));  put(5, ins(0, 13)); put(6, ins(7, 0));
    put(10, 12'hFFF); put(11, 12'h002);
    dly_mode = -1;
    do_reset(1'b0);
    run_until_halt(200);
    chk("p2_add_wrap", 32'(mem[12]), 32'h001);
    chk("p2_dec_wrap", 32'(mem[13]), 32'hFFF);
    chk("p2_ac_pc", 32'({ac_out, pc_out}), 32'({12'hFFF, 9'd7}));

    // BZ taken, BZ not taken, BR.
    clear_mem();
    put(0, ins(5, 0)); put(1, ins(4, 20)); put(20, ins(6, 0)); put(21, ins(4, 30));
    put(22, ins(3, 5)); put(5, ins(7, 0));
    dly_mode = 0;
    do_reset(1'b0);
    run_until_halt(100);
    chk("p3_pc", 32'(pc_out), 32'd6);
    chk("p3_ac", 32'(ac_out), 32'hFFF);
    chk("p3_cycles", 32'(halted_at), 32'd13);

    // Slow memory: ack 3 cycles after each request.
    load_prog1();
    dly_mode = 3;
    do_reset(1'b0);
    run_until_halt(200);
    chk("p4_ac", 32'(ac_out), 32'd12);
    chk("p4_mem12", 32'(mem[12]), 32'd12);
    chk("p4_cycles", 32'(halted_at), 32'd36);

    // Reset while a ST write is waiting for ack.
    load_prog1();
    dly_mode = 5;
    do_reset(1'b0);
    begin
      int n;
      n = 0;
      while (bus.mem_wr !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("st_reached", 32'(bus.mem_wr), 32'd1);
    end
    do_reset(1'b1);
    run_until_halt(300);
    chk("p6a_mem12", 32'(mem[12]), 32'd12);

    // Reset out of HALT, then reset with ack held high.
    dly_mode = 0;
    do_reset(1'b0);
    run_until_halt(100);
    chk("p6b_ac", 32'(ac_out), 32'd12);
    force_ack = 1'b1;
    do_reset(1'b0);
    force_ack = 1'b0;
    run_until_halt(100);
    chk("p6c_cycles", 32'(halted_at), 32'd15);

    // Random programs with random ack timing.
    dly_mode = -1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 512; i++) begin
        logic [DW-1:0] v;
        v = DW'($urandom);
        if (v[11:9] == 3'd7 && $urandom_range(0, 3) != 0) v[11:9] = 3'd3;
        put(i, v);
      end
      do_reset(1'b0);
      repeat (400) @(posedge clk);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
